// File: rtl/gate_sweep_if.sv
// Handshake and result bundle between a sweep host and gate_sweep_ctrl.
// The host (master) owns start/abort and feeds back the two gate outputs.
// The controller (slave) owns the drive vector and the sweep results.
interface gate_sweep_if #(
  parameter int N_IN = 2
);
  logic                   start;
  logic                   abort;
  logic                   s_a;
  logic                   s_b;
  logic [N_IN-1:0]        drive;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic [N_IN-1:0]        first_err_idx;
  logic [(1<<N_IN)-1:0]   result_vec;

  modport master (
    output start, abort, s_a, s_b,
    input  drive, busy, done, pass, err_count, first_err_idx, result_vec
  );

  modport slave (
    input  start, abort, s_a, s_b,
    output drive, busy, done, pass, err_count, first_err_idx, result_vec
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for a pair of combinational gate implementations.
// Walks every input vector, waits SETTLE cycles on each, then samples both
// outputs, recording A's truth table and counting A/B disagreements.
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  gate_sweep_if.slave  bus
);
  localparam int              VEC      = 1 << N_IN;
  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST     = '1;
  localparam logic [N_IN-1:0] DRV_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_IN-1:0]   drive_q, drive_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic [VEC-1:0]    result_q, result_d;
  logic              pass_q, pass_d;
  logic              busy_o, done_o;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort only matters while the sweep is running
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = (SETTLE_L != 4'd0) ? S_WAIT : S_SAMPLE;
      S_WAIT: begin
        if (bus.abort)            state_d = S_IDLE;
        else if (cnt_q <= 4'd1)   state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (bus.abort)            state_d = S_IDLE;
        else if (drive_q == LAST) state_d = S_DONE;
        else                      state_d = (SETTLE_L != 4'd0) ? S_WAIT : S_SAMPLE;
      end
      S_DONE:                     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Output decode straight from the registered state
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_WAIT, S_SAMPLE: busy_o = 1'b1;
      S_DONE:           done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: settle counter, drive vector and sweep results
  always_comb begin
    cnt_d    = cnt_q;
    drive_d  = drive_q;
    err_d    = err_q;
    first_d  = first_q;
    result_d = result_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d    = '0;
          first_d  = '0;
          result_d = '0;
          drive_d  = '0;
          pass_d   = 1'b0;
          cnt_d    = SETTLE_L;
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          drive_d = '0;
          pass_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        // An abort in the sample cycle discards that sample entirely
        if (bus.abort) begin
          drive_d = '0;
          pass_d  = 1'b0;
        end else begin
          result_d[drive_q] = bus.s_a;
          if (bus.s_a != bus.s_b) begin
            err_d = err_q + ERR_ONE;
            if (err_q == '0) first_d = drive_q;
          end
          if (drive_q != LAST) begin
            drive_d = drive_q + DRV_ONE;
            cnt_d   = SETTLE_L;
          end
        end
      end
      S_DONE:  pass_d = (err_q == '0);
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      drive_q  <= '0;
      err_q    <= '0;
      first_q  <= '0;
      result_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      drive_q  <= drive_d;
      err_q    <= err_d;
      first_q  <= first_d;
      result_q <= result_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.drive         = drive_q;
  assign bus.busy          = busy_o;
  assign bus.done          = done_o;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;
  assign bus.result_vec    = result_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0) driving a
// modelled gate pair a|~b with selectable faults injected into B.
module tb_gate_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_sweep_if #(.N_IN(2)) if1 ();
  gate_sweep_if #(.N_IN(2)) if0 ();

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  gate_sweep_ctrl #(.N_IN(2), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  // Gate pair model: A is the reference, B may carry an injected fault
  int fault = 0;
  function automatic logic gate_a(input logic [1:0] d);
    return d[1] | ~d[0];
  endfunction
  function automatic logic gate_b(input logic [1:0] d, input int f);
    logic r;
    r = gate_a(d);
    if (f == 1 && d == 2'd1) r = ~r;
    if (f == 2)              r = ~r;
    if (f == 3 && d == 2'd3) r = ~r;
    return r;
  endfunction

  assign if1.s_a = gate_a(if1.drive);
  assign if1.s_b = gate_b(if1.drive, fault);
  assign if0.s_a = gate_a(if0.drive);
  assign if0.s_b = gate_b(if0.drive, fault);

  // Observation mux so one task can exercise either instance
  int sel = 1;
  logic [1:0] m_drive, m_first;
  logic [2:0] m_err;
  logic [3:0] m_result;
  logic       m_busy, m_done, m_pass;
  assign m_drive  = (sel == 1) ? if1.drive         : if0.drive;
  assign m_first  = (sel == 1) ? if1.first_err_idx : if0.first_err_idx;
  assign m_err    = (sel == 1) ? if1.err_count     : if0.err_count;
  assign m_result = (sel == 1) ? if1.result_vec    : if0.result_vec;
  assign m_busy   = (sel == 1) ? if1.busy          : if0.busy;
  assign m_done   = (sel == 1) ? if1.done          : if0.done;
  assign m_pass   = (sel == 1) ? if1.pass          : if0.pass;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         flt;
    logic [3:0] result;
    logic [2:0] err;
    logic [1:0] first;
    logic       pass;
  } vec_t;

  typedef struct {
    logic [3:0] result;
    logic [2:0] err;
    logic [1:0] first;
    logic       pass;
    int         busy_n;
    int         done_cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic set_start(input logic v, input logic with_abort);
    if (sel == 1) begin if1.start = v; if1.abort = v & with_abort; end
    else          begin if0.start = v; if0.abort = v & with_abort; end
  endtask

  // One full sweep on the selected instance; expectations go through the queue
  task automatic do_sweep(input string tag, input exp_t e, input int settle, input logic with_abort);
    exp_t got;
    int   busy_n, done_c;
    @(negedge clk);
    set_start(1'b1, with_abort);
    sb_q.push_back(e);
    @(negedge clk);
    set_start(1'b0, 1'b0);
    busy_n = 0;
    done_c = 0;
    for (int c = 1; c <= 40 && done_c == 0; c++) begin
      if (c == 1) begin
        chk({tag, " err_cleared"}, m_err, 0);
        chk({tag, " pass_cleared"}, m_pass, 0);
      end
      if (m_busy) begin
        busy_n++;
        chk({tag, " drive_step"}, m_drive, (c - 1) / (settle + 1));
      end
      if (m_done) done_c = c;
      else        @(negedge clk);
    end
    if (done_c == 0) chk({tag, " done_timeout"}, 0, 1);
    got = sb_q.pop_front();
    chk({tag, " busy_cycles"}, busy_n, got.busy_n);
    chk({tag, " done_cycle"}, done_c, got.done_cyc);
    chk({tag, " drive_hold"}, m_drive, 3);
    chk({tag, " result_vec"}, m_result, got.result);
    chk({tag, " err_count"}, m_err, got.err);
    if (got.err != 0) chk({tag, " first_err_idx"}, m_first, got.first);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, m_done, 0);
    chk({tag, " pass"}, m_pass, got.pass);
    $display("sweep %s: busy=%0d done@%0d result=%b err=%0d first=%0d pass=%0d",
             tag, busy_n, done_c, m_result, m_err, m_first, m_pass);
  endtask

  vec_t tbl[4];

  initial begin
    exp_t e;
    int   saw_done;
    tbl[0] = '{2, 4'b1101, 3'd4, 2'd0, 1'b0};
    tbl[1] = '{0, 4'b1101, 3'd0, 2'd0, 1'b1};
    tbl[2] = '{1, 4'b1101, 3'd1, 2'd1, 1'b0};
    tbl[3] = '{3, 4'b1101, 3'd1, 2'd3, 1'b0};

    if1.start = 0; if1.abort = 0;
    if0.start = 0; if0.abort = 0;
    rst_n = 1'b0;
    #12;
    chk("reset drive", if1.drive, 0);
    chk("reset busy", if1.busy, 0);
    chk("reset done", if1.done, 0);
    chk("reset pass", if1.pass, 0);
    chk("reset err", if1.err_count, 0);
    chk("reset result", if1.result_vec, 0);
    $display("reset: drive=%0d busy=%0d err=%0d", if1.drive, if1.busy, if1.err_count);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sweeps on the SETTLE=1 instance
    sel = 1;
    for (int i = 0; i < 4; i++) begin
      fault = tbl[i].flt;
      e = '{tbl[i].result, tbl[i].err, tbl[i].first, tbl[i].pass, 8, 9};
      do_sweep($sformatf("s1_fault%0d", tbl[i].flt), e, 1, 1'b0);
    end

    // SETTLE=0 instance with the matching pair
    sel = 0;
    fault = 0;
    e = '{4'b1101, 3'd0, 2'd0, 1'b1, 4, 5};
    do_sweep("s0_match", e, 0, 1'b0);

    // Abort after the second sample, with a stray start mid-sweep
    sel = 1;
    fault = 0;
    @(negedge clk); if1.start = 1;
    @(negedge clk); if1.start = 0;          // cycle 1 (WAIT, drive 0)
    @(negedge clk); if1.start = 1;          // cycle 2 (SAMPLE 0), must be ignored
    @(negedge clk); if1.start = 0;          // cycle 3
    chk("abort stray_start_ignored", if1.drive, 1);
    @(negedge clk);                         // cycle 4 (SAMPLE 1)
    @(negedge clk); if1.abort = 1;          // cycle 5 (WAIT, drive 2)
    @(negedge clk); if1.abort = 0;          // cycle 6
    chk("abort busy", if1.busy, 0);
    chk("abort drive", if1.drive, 0);
    chk("abort pass", if1.pass, 0);
    chk("abort partial_result", if1.result_vec, 4'b0001);
    saw_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (if1.done) saw_done++;
      @(negedge clk);
    end
    chk("abort no_done", saw_done, 0);
    $display("abort: drive=%0d busy=%0d result=%b done_seen=%0d",
             if1.drive, if1.busy, if1.result_vec, saw_done);

    // Restart with start and abort both high in IDLE: start wins
    e = '{4'b1101, 3'd0, 2'd0, 1'b1, 8, 9};
    do_sweep("s1_restart_start_abort", e, 1, 1'b1);

    // Asynchronous reset in the middle of a mismatching sweep
    fault = 2;
    @(negedge clk); if1.start = 1;
    @(negedge clk); if1.start = 0;
    for (int c = 0; c < 4; c++) @(negedge clk);   // cycle 5, two samples taken
    chk("midreset pre_err", if1.err_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset drive", if1.drive, 0);
    chk("midreset busy", if1.busy, 0);
    chk("midreset err", if1.err_count, 0);
    chk("midreset result", if1.result_vec, 0);
    saw_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if1.done) saw_done++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if1.done || if1.busy) saw_done++;
    end
    chk("midreset stays_idle", saw_done, 0);
    $display("midreset: drive=%0d busy=%0d err=%0d activity=%0d",
             if1.drive, if1.busy, if1.err_count, saw_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
